// File: rtl/bus_seq_pkg.sv
// Shared constants, state encoding and IR field helpers for the bus transfer sequencer.
package bus_seq_pkg;

  // Register file entry indices; MEM_SEL selects memory data onto the bus.
  localparam int PC_IDX  = 15;
  localparam int IR_IDX  = 16;
  localparam int Y_IDX   = 17;
  localparam int ZLO_IDX = 18;
  localparam int ZHI_IDX = 19;
  localparam int MAR_IDX = 20;
  localparam int HI_IDX  = 21;
  localparam int LO_IDX  = 22;
  localparam int MDR_IDX = 23;
  localparam int MEM_SEL = 24;

  // Opcodes; anything above OP_NOP is illegal.
  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_AND = 5'd2;
  localparam logic [4:0] OP_OR  = 5'd3;
  localparam logic [4:0] OP_MUL = 5'd4;
  localparam logic [4:0] OP_DIV = 5'd5;
  localparam logic [4:0] OP_NOP = 5'd6;

  // IR field bit positions.
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int RA_MSB = 26;
  localparam int RA_LSB = 23;
  localparam int RB_MSB = 22;
  localparam int RB_LSB = 19;
  localparam int RC_MSB = 18;
  localparam int RC_LSB = 15;

  // Register field value that may not be named by an instruction.
  localparam logic [3:0] REG_ILLEGAL = 4'd15;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_T0    = 4'd1,
    ST_T1    = 4'd2,
    ST_T2    = 4'd3,
    ST_T3    = 4'd4,
    ST_T4    = 4'd5,
    ST_T5    = 4'd6,
    ST_T6    = 4'd7,
    ST_FAULT = 4'd8
  } state_e;

  // True when opcode and all three register fields are usable.
  function automatic logic fields_legal(input logic [4:0] op_v, input logic [3:0] ra_v,
                                        input logic [3:0] rb_v, input logic [3:0] rc_v);
    fields_legal = (op_v <= OP_NOP) && (ra_v != REG_ILLEGAL) &&
                   (rb_v != REG_ILLEGAL) && (rc_v != REG_ILLEGAL);
  endfunction

  // Multiply and divide produce a 64-bit result and need the extra HI/LO T-state.
  function automatic logic op_is_long(input logic [4:0] op_v);
    op_is_long = (op_v == OP_MUL) || (op_v == OP_DIV);
  endfunction

endpackage

// File: rtl/bus_seq_decode.sv
// Combinational decode of sequencer state (plus IR and mem_ready) into datapath controls.
module bus_seq_decode
  import bus_seq_pkg::*;
#(
  parameter int BITS      = 32,
  parameter int REGISTERS = 24
) (
  input  state_e               state,
  input  logic [BITS-1:0]      ir,
  input  logic                 mem_ready,
  output logic [REGISTERS-1:0] load_enable,
  output logic [4:0]           bus_sel,
  output logic [2:0]           alu_op,
  output logic                 inc_pc,
  output logic                 mem_read,
  output logic                 done,
  output logic                 ir_ok,
  output logic                 ir_nop,
  output logic                 ir_long
);

  logic [4:0] op_s;
  logic [3:0] ra_s;
  logic [3:0] rb_s;
  logic [3:0] rc_s;
  logic       unused_ir_s;

  assign op_s        = ir[OP_MSB:OP_LSB];
  assign ra_s        = ir[RA_MSB:RA_LSB];
  assign rb_s        = ir[RB_MSB:RB_LSB];
  assign rc_s        = ir[RC_MSB:RC_LSB];
  assign unused_ir_s = ^ir[RC_LSB-1:0];

  assign ir_ok   = fields_legal(op_s, ra_s, rb_s, rc_s);
  assign ir_nop  = (op_s == OP_NOP);
  assign ir_long = op_is_long(op_s);

  // One-hot load strobe for a single register file entry.
  function automatic logic [REGISTERS-1:0] sel_reg(input int idx);
    sel_reg = {{(REGISTERS-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Per-state datapath controls; everything idles at zero unless the state drives it.
  always_comb begin
    load_enable = '0;
    bus_sel     = 5'd0;
    alu_op      = 3'd0;
    inc_pc      = 1'b0;
    mem_read    = 1'b0;
    done        = 1'b0;
    case (state)
      ST_T0: begin
        bus_sel     = 5'(PC_IDX);
        load_enable = sel_reg(MAR_IDX) | sel_reg(ZLO_IDX) | sel_reg(ZHI_IDX);
        inc_pc      = 1'b1;
      end
      ST_T1: begin
        bus_sel  = 5'(MEM_SEL);
        mem_read = 1'b1;
        if (mem_ready) begin
          load_enable = sel_reg(MDR_IDX) | sel_reg(PC_IDX);
        end else begin
          load_enable = '0;
        end
      end
      ST_T2: begin
        bus_sel     = 5'(MDR_IDX);
        load_enable = sel_reg(IR_IDX);
      end
      ST_T3: begin
        if (ir_ok && !ir_nop) begin
          bus_sel     = {1'b0, rb_s};
          load_enable = sel_reg(Y_IDX);
        end else if (ir_ok) begin
          done = 1'b1;
        end else begin
          done = 1'b0;
        end
      end
      ST_T4: begin
        bus_sel     = {1'b0, rc_s};
        alu_op      = op_s[2:0];
        load_enable = sel_reg(ZLO_IDX) | sel_reg(ZHI_IDX);
      end
      ST_T5: begin
        bus_sel = 5'(ZLO_IDX);
        if (ir_long) begin
          load_enable = sel_reg(LO_IDX);
        end else begin
          load_enable = sel_reg(int'(ra_s));
          done        = 1'b1;
        end
      end
      ST_T6: begin
        bus_sel     = 5'(ZHI_IDX);
        load_enable = sel_reg(HI_IDX);
        done        = 1'b1;
      end
      default: begin
        load_enable = '0;
      end
    endcase
  end

endmodule

// File: rtl/bus_transfer_sequencer.sv
// Fetch/execute sequencer: state register, memory wait timeout and sticky fault flag.
module bus_transfer_sequencer
  import bus_seq_pkg::*;
#(
  parameter int BITS        = 32,
  parameter int REGISTERS   = 24,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 start,
  input  logic [BITS-1:0]      ir,
  input  logic                 mem_ready,
  output logic [REGISTERS-1:0] load_enable,
  output logic [4:0]           bus_sel,
  output logic                 mem_read,
  output logic                 inc_pc,
  output logic [2:0]           alu_op,
  output logic                 busy,
  output logic                 done,
  output logic                 fault
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  // Last waiting count before the wait for memory is abandoned.
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  state_e        state_r;
  state_e        state_s;
  logic [CW-1:0] cnt_r;
  logic          fault_r;
  logic          ir_ok_s;
  logic          ir_nop_s;
  logic          ir_long_s;

  bus_seq_decode #(
    .BITS      (BITS),
    .REGISTERS (REGISTERS)
  ) u_decode (
    .state       (state_r),
    .ir          (ir),
    .mem_ready   (mem_ready),
    .load_enable (load_enable),
    .bus_sel     (bus_sel),
    .alu_op      (alu_op),
    .inc_pc      (inc_pc),
    .mem_read    (mem_read),
    .done        (done),
    .ir_ok       (ir_ok_s),
    .ir_nop      (ir_nop_s),
    .ir_long     (ir_long_s)
  );

  assign busy  = (state_r != ST_IDLE);
  assign fault = fault_r;

  // State register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; start only matters in IDLE and the final T-state.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = ST_T0;
        else       state_s = ST_IDLE;
      end
      ST_T0: state_s = ST_T1;
      ST_T1: begin
        if (mem_ready)              state_s = ST_T2;
        else if (cnt_r == CNT_LAST) state_s = ST_FAULT;
        else                        state_s = ST_T1;
      end
      ST_T2: state_s = ST_T3;
      ST_T3: begin
        if (!ir_ok_s)     state_s = ST_FAULT;
        else if (ir_nop_s) state_s = ST_IDLE;
        else               state_s = ST_T4;
      end
      ST_T4: state_s = ST_T5;
      ST_T5: begin
        if (ir_long_s)  state_s = ST_T6;
        else if (start) state_s = ST_T0;
        else            state_s = ST_IDLE;
      end
      ST_T6: begin
        if (start) state_s = ST_T0;
        else       state_s = ST_IDLE;
      end
      ST_FAULT: state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Count consecutive T1 cycles spent waiting on memory; any other cycle clears it.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt_r <= '0;
    end else if ((state_r == ST_T1) && !mem_ready) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= '0;
    end
  end

  // Sticky fault: set on entry to FAULT, cleared only when IDLE accepts a start.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      fault_r <= 1'b0;
    end else if (state_s == ST_FAULT) begin
      fault_r <= 1'b1;
    end else if ((state_r == ST_IDLE) && start) begin
      fault_r <= 1'b0;
    end else begin
      fault_r <= fault_r;
    end
  end

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Randomized bench: builds the expected per-cycle output trace of each instruction
// from the documented T-state sequence and compares the DUT against it.
module tb_bus_transfer_sequencer;

  localparam int TO = 15;

  logic        clk;
  logic        clr;
  logic        start;
  logic [31:0] ir;
  logic        mem_ready;
  logic [23:0] load_enable;
  logic [4:0]  bus_sel;
  logic        mem_read;
  logic        inc_pc;
  logic [2:0]  alu_op;
  logic        busy;
  logic        done;
  logic        fault;

  bus_transfer_sequencer #(.BITS(32), .REGISTERS(24), .MEM_TIMEOUT(TO)) dut (
    .clk         (clk),
    .clr         (clr),
    .start       (start),
    .ir          (ir),
    .mem_ready   (mem_ready),
    .load_enable (load_enable),
    .bus_sel     (bus_sel),
    .mem_read    (mem_read),
    .inc_pc      (inc_pc),
    .alu_op      (alu_op),
    .busy        (busy),
    .done        (done),
    .fault       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        mr;
    logic [31:0] ir;
    logic [23:0] le;
    int          bs;   // -1: not checked
    logic        mrd;
    logic        inc;
    int          alu;  // -1: not checked
    logic        bsy;
    logic        dn;
    logic        flt;
  } ent_t;

  ent_t tq[$];
  int   checks_n = 0;
  int   errors_n = 0;
  int   cyc = 0;
  logic fault_m;
  logic hold_start;
  logic linked;

  // Single comparison point for every check in the bench.
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_n++;
    if (got !== exp) begin
      errors_n++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [23:0] rbit(input int i);
    logic [23:0] one;
    one = 24'd1;
    return one << i;
  endfunction

  function automatic logic rnd();
    return 1'($urandom % 2);
  endfunction

  function automatic logic rst_();
    return hold_start ? 1'b1 : rnd();
  endfunction

  function automatic logic [31:0] mk(input int op, input int ra, input int rb, input int rc);
    return {5'(op), 4'(ra), 4'(rb), 4'(rc), 15'd0};
  endfunction

  task automatic put(input logic st, input logic mr, input logic [31:0] irv, input logic [23:0] le,
                     input int bs, input logic mrd, input logic inc, input int alu,
                     input logic bsy, input logic dn);
    ent_t e;
    e.st = st; e.mr = mr; e.ir = irv; e.le = le; e.bs = bs; e.mrd = mrd; e.inc = inc;
    e.alu = alu; e.bsy = bsy; e.dn = dn; e.flt = fault_m;
    tq.push_back(e);
  endtask

  // Expected trace of one instruction; linked_out says whether the next one follows with no IDLE.
  task automatic gen(input logic [31:0] irv, input int delay, input logic chained,
                     input logic chain_next, output logic linked_out);
    int op, ra, rb, rc;
    op = int'(irv[31:27]); ra = int'(irv[26:23]); rb = int'(irv[22:19]); rc = int'(irv[18:15]);
    linked_out = 1'b0;
    if (!chained) begin
      for (int g = 0; g < int'($urandom % 3); g++) put(1'b0, rnd(), irv, 24'd0, 0, 1'b0, 1'b0, -1, 1'b0, 1'b0);
      put(1'b1, rnd(), irv, 24'd0, 0, 1'b0, 1'b0, -1, 1'b0, 1'b0);
      fault_m = 1'b0;
    end
    put(rst_(), rnd(), irv, rbit(20) | rbit(18) | rbit(19), 15, 1'b0, 1'b1, -1, 1'b1, 1'b0);
    for (int w = 0; w < delay && w < TO; w++)
      put(rst_(), 1'b0, irv, 24'd0, 24, 1'b1, 1'b0, -1, 1'b1, 1'b0);
    if (delay >= TO) begin
      fault_m = 1'b1;
      put(rst_(), rnd(), irv, 24'd0, -1, 1'b0, 1'b0, -1, 1'b1, 1'b0);
      return;
    end
    put(rst_(), 1'b1, irv, rbit(23) | rbit(15), 24, 1'b1, 1'b0, -1, 1'b1, 1'b0);
    put(rst_(), rnd(), irv, rbit(16), 23, 1'b0, 1'b0, -1, 1'b1, 1'b0);
    if (op > 6 || ra == 15 || rb == 15 || rc == 15) begin
      put(rst_(), rnd(), irv, 24'd0, -1, 1'b0, 1'b0, -1, 1'b1, 1'b0);
      fault_m = 1'b1;
      put(rst_(), rnd(), irv, 24'd0, -1, 1'b0, 1'b0, -1, 1'b1, 1'b0);
      return;
    end
    if (op == 6) begin
      put(1'b0, rnd(), irv, 24'd0, -1, 1'b0, 1'b0, -1, 1'b1, 1'b1);
      return;
    end
    put(rst_(), rnd(), irv, rbit(17), rb, 1'b0, 1'b0, -1, 1'b1, 1'b0);
    put(rst_(), rnd(), irv, rbit(18) | rbit(19), rc, 1'b0, 1'b0, op, 1'b1, 1'b0);
    if (op == 4 || op == 5) begin
      put(rst_(), rnd(), irv, rbit(22), 18, 1'b0, 1'b0, -1, 1'b1, 1'b0);
      put(chain_next, rnd(), irv, rbit(21), 19, 1'b0, 1'b0, -1, 1'b1, 1'b1);
    end else begin
      put(chain_next, rnd(), irv, rbit(ra), 18, 1'b0, 1'b0, -1, 1'b1, 1'b1);
    end
    linked_out = chain_next;
  endtask

  task automatic gen_next(input logic [31:0] irv, input int delay, input logic chain_next);
    logic l;
    gen(irv, delay, linked, chain_next, l);
    linked = l;
  endtask

  // Play up to n trace entries: drive after the rising edge, compare on the falling edge.
  task automatic run_n(input int n);
    ent_t e;
    for (int i = 0; i < n && tq.size() > 0; i++) begin
      e = tq.pop_front();
      @(posedge clk); #1;
      start = e.st; mem_ready = e.mr; ir = e.ir;
      @(negedge clk);
      cyc++;
      check_val("load_enable", 32'(load_enable), 32'(e.le));
      if (e.bs >= 0) check_val("bus_sel", 32'(bus_sel), 32'(e.bs));
      check_val("mem_read", 32'(mem_read), 32'(e.mrd));
      check_val("inc_pc", 32'(inc_pc), 32'(e.inc));
      if (e.alu >= 0) check_val("alu_op", 32'(alu_op), 32'(e.alu));
      check_val("busy", 32'(busy), 32'(e.bsy));
      check_val("done", 32'(done), 32'(e.dn));
      check_val("fault", 32'(fault), 32'(e.flt));
    end
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_le"}, 32'(load_enable), 32'd0);
    check_val({tag, "_bus_sel"}, 32'(bus_sel), 32'd0);
    check_val({tag, "_mem_read"}, 32'(mem_read), 32'd0);
    check_val({tag, "_inc_pc"}, 32'(inc_pc), 32'd0);
    check_val({tag, "_alu_op"}, 32'(alu_op), 32'd0);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_done"}, 32'(done), 32'd0);
    check_val({tag, "_fault"}, 32'(fault), 32'd0);
  endtask

  initial begin
    int op, r, dly;
    clr = 1'b0; start = 1'b0; mem_ready = 1'b0; ir = 32'd0;
    fault_m = 1'b0; hold_start = 1'b0; linked = 1'b0;
    #12;
    check_quiet("reset");
    #10 clr = 1'b1;

    // Directed cases.
    gen_next(mk(0, 1, 2, 3), 0, 1'b0);
    gen_next(mk(4, 4, 5, 6), 0, 1'b0);
    gen_next(mk(0, 1, 2, 3), 3, 1'b0);
    gen_next(mk(0, 1, 2, 3), 14, 1'b0);
    gen_next(mk(0, 1, 2, 3), 20, 1'b0);
    gen_next(mk(2, 7, 8, 9), 0, 1'b0);
    gen_next(mk(7, 1, 2, 3), 0, 1'b0);
    gen_next(mk(0, 1, 15, 3), 0, 1'b0);
    gen_next(mk(6, 1, 2, 3), 0, 1'b0);
    hold_start = 1'b1;
    gen_next(mk(0, 1, 2, 3), 0, 1'b1);
    gen_next(mk(1, 7, 8, 9), 0, 1'b0);
    hold_start = 1'b0;

    // Random instructions.
    for (int k = 0; k < 40; k++) begin
      op = int'($urandom % 8);
      r  = int'($urandom % 8);
      if (r < 5)       dly = r;
      else if (r == 7) dly = TO + int'($urandom % 3);
      else             dly = int'($urandom_range(5, 14));
      gen_next(mk(op, int'($urandom % 16), int'($urandom % 16), int'($urandom % 16)), dly, rnd());
    end
    run_n(tq.size());

    // Reset in T4: outputs drop at once and nothing loads after release.
    linked = 1'b0;
    fault_m = fault;
    gen_next(mk(0, 1, 2, 3), 0, 1'b0);
    while (tq.size() > 0 && !(tq[0].alu >= 0)) run_n(1);
    run_n(1);
    tq.delete();
    #1 clr = 1'b0;
    #1 check_quiet("clr_mid");
    #2 clr = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1 start = 1'b0; mem_ready = rnd();
      @(negedge clk);
      check_val("post_clr_le", 32'(load_enable), 32'd0);
      check_val("post_clr_busy", 32'(busy), 32'd0);
    end
    fault_m = 1'b0;
    linked = 1'b0;
    gen_next(mk(5, 3, 4, 5), 2, 1'b0);
    run_n(tq.size());

    $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
    $finish;
  end

endmodule
